// File: rtl/apb_decode_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_decode_bridge
// Brief    : Registered APB 1-to-NUM_SLV address decoder with local decode
//            error responses; optional access timeout (APB_DECODE_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module apb_decode_bridge #(
  parameter int NUM_SLV     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 12,
  parameter int SEL_W       = $clog2(NUM_SLV),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_s_psel,
  input  logic                      i_s_penable,
  input  logic                      i_s_pwrite,
  input  logic [ADDR_W-1:0]         i_s_paddr,
  input  logic [DATA_W-1:0]         i_s_pwdata,
  output logic                      o_s_pready,
  output logic [DATA_W-1:0]         o_s_prdata,
  output logic                      o_s_pslverr,
  output logic [NUM_SLV-1:0]        o_m_psel,
  output logic                      o_m_penable,
  output logic                      o_m_pwrite,
  output logic [ADDR_W-1:0]         o_m_paddr,
  output logic [DATA_W-1:0]         o_m_pwdata,
  input  logic [NUM_SLV-1:0]        i_m_pready,
  input  logic [NUM_SLV*DATA_W-1:0] i_m_prdata,
  input  logic [NUM_SLV-1:0]        i_m_pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic [SEL_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic [SEL_W-1:0]    w_idx;
  logic                w_dec_err;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_expire;
  logic                w_capture;
  logic                w_done;
  logic                w_tmo;
  logic                w_sel_en;
  logic                w_penable;
  logic                w_pready;

  assign w_idx       = i_s_paddr[SEL_LSB +: SEL_W];
  // Anything above the select field must be zero for the address to map.
  assign w_dec_err   = (int'(w_idx) >= NUM_SLV) ||
                       ((i_s_paddr >> (SEL_LSB + SEL_W)) != '0);
  assign w_sel_ready = i_m_pready[r_idx];
  assign w_sel_rdata = i_m_prdata[int'(r_idx)*DATA_W +: DATA_W];

`ifdef APB_DECODE_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYC);
  logic [c_CNT_W-1:0] r_cnt;

  assign w_expire = (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

  // Held at zero outside ACCESS so it starts fresh on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_cnt <= '0;
    end else if (!w_sel_ready && !w_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    w_sel_en  = 1'b0;
    w_penable = 1'b0;
    w_pready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_s_psel && !i_s_penable) begin
          w_capture = 1'b1;
          w_next    = w_dec_err ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_sel_en = 1'b1;
        w_next   = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_sel_en  = 1'b1;
        w_penable = 1'b1;
        // A ready coinciding with expiry is a normal completion.
        if (w_sel_ready) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end else if (w_expire) begin
          w_tmo  = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_pready = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= i_s_paddr;
      r_wdata <= i_s_pwdata;
      r_write <= i_s_pwrite;
      r_idx   <= w_idx;
      r_rdata <= '0;
      r_err   <= w_dec_err;
    end else if (w_done) begin
      r_rdata <= r_write ? '0 : w_sel_rdata;
      r_err   <= i_m_pslverr[r_idx];
    end else if (w_tmo) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  assign o_m_psel    = w_sel_en ? (NUM_SLV'(1) << r_idx) : '0;
  assign o_m_penable = w_penable;
  assign o_m_pwrite  = r_write;
  assign o_m_paddr   = r_addr;
  assign o_m_pwdata  = r_wdata;
  assign o_s_pready  = w_pready;
  assign o_s_prdata  = w_pready ? r_rdata : '0;
  assign o_s_pslverr = w_pready & r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_decode_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_decode_bridge
// Brief    : Randomized self-checking bench for apb_decode_bridge against a
//            transaction-level latency/response model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_decode_bridge;
  localparam int NUM_SLV = 4;
  localparam int SEL_LSB = 12;
  localparam int TMO     = 8;

  logic         clk;
  logic         rst;
  logic         s_psel, s_penable, s_pwrite;
  logic [31:0]  s_paddr, s_pwdata;
  logic         s_pready, s_pslverr;
  logic [31:0]  s_prdata;
  logic [3:0]   m_psel;
  logic         m_penable, m_pwrite;
  logic [31:0]  m_paddr, m_pwdata;
  logic [3:0]   m_pready, m_pslverr;
  logic [127:0] m_prdata;

  int n_tests = 0;
  int n_fail  = 0;

  apb_decode_bridge #(
    .NUM_SLV(NUM_SLV), .ADDR_W(32), .DATA_W(32), .SEL_LSB(SEL_LSB),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_s_psel(s_psel), .i_s_penable(s_penable), .i_s_pwrite(s_pwrite),
    .i_s_paddr(s_paddr), .i_s_pwdata(s_pwdata),
    .o_s_pready(s_pready), .o_s_prdata(s_prdata), .o_s_pslverr(s_pslverr),
    .o_m_psel(m_psel), .o_m_penable(m_penable), .o_m_pwrite(m_pwrite),
    .o_m_paddr(m_paddr), .o_m_pwdata(m_pwdata),
    .i_m_pready(m_pready), .i_m_prdata(m_prdata), .i_m_pslverr(m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {24'h0, s_pready, s_prdata, s_pslverr, m_psel, m_penable,
            m_pwrite, m_paddr, m_pwdata};
  endfunction

  // An address maps exactly when it lies below NUM_SLV windows of 4 KiB.
  function automatic bit mapped(input logic [31:0] a);
    return {32'h0, a} < 64'(NUM_SLV) * 64'(1 << SEL_LSB);
  endfunction

  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int nwait, input logic [127:0] rd_all, input logic [3:0] err_all);
    bit          map, tmo;
    int          idx, lat, last_sel;
    logic [3:0]  oh, rdy, esel;
    logic [31:0] erd;
    bit          eerr, een, ersp;
    map = mapped(addr);
    idx = map ? int'(addr >> SEL_LSB) : 0;
    oh  = map ? (4'b0001 << idx) : 4'b0000;
    tmo = 1'b0;
`ifdef APB_DECODE_TIMEOUT_EN
    if (map && nwait >= TMO) tmo = 1'b1;
`endif
    if (!map) begin
      lat = 1; last_sel = 0; erd = 32'h0; eerr = 1'b1;
    end else if (tmo) begin
      lat = 2 + TMO; last_sel = 1 + TMO; erd = 32'h0; eerr = 1'b1;
    end else begin
      lat = 3 + nwait; last_sel = 2 + nwait;
      erd = wr ? 32'h0 : rd_all[idx*32 +: 32];
      eerr = err_all[idx];
    end
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
    m_prdata = rd_all; m_pslverr = err_all; m_pready = 4'($urandom) & ~oh;
    @(posedge clk); #1;
    s_penable = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      rdy = 4'($urandom) & ~oh;
      if (map && !tmo && k == 2 + nwait) rdy = rdy | oh;
      m_pready = rdy;
      esel = (k <= last_sel) ? oh : 4'b0000;
      een  = (k >= 2) && (k <= last_sel);
      ersp = (k == lat);
      check("ctl", {s_pready, s_pslverr, s_prdata, m_penable, m_psel},
            {ersp, ersp & eerr, ersp ? erd : 32'h0, een, esel});
      if (k <= last_sel)
        check("mbus", {m_pwrite, m_paddr, m_pwdata}, {wr, addr, wdata});
      if (k < lat) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Leaves completer 0 stalled for n cycles, then resets mid-access.
  task automatic stall_then_reset(input int n);
    int seen;
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0000_0040;
    m_pready = 4'b0000;
    @(posedge clk); #1;
    s_penable = 1'b1;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (s_pready) seen++;
    end
    check("stall_pready", 128'(seen), 128'd0);
    check("stall_sel", {m_penable, m_psel}, {1'b1, 4'b0001});
    rst = 1'b1; s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst", all_outs(), 128'h0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit          wr;
    logic [31:0] addr;
    int          nw;
    rst = 1'b1; s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = 32'h0; s_pwdata = 32'h0;
    m_pready = 4'h0; m_prdata = '0; m_pslverr = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", all_outs(), 128'h0);
    rst = 1'b0; s_psel = 1'b0;

    do_xfer(1'b1, 32'h0000_1004, 32'h1234_5678, 0, rnd128(), 4'h0);
    do_xfer(1'b0, 32'h0000_3010, 32'h0, 2,
            {32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'h0);
    do_xfer(1'b0, 32'h0000_5000, 32'h0, 0, rnd128(), 4'hF);
    do_xfer(1'b1, 32'h0001_0000, 32'hA5A5_A5A5, 0, rnd128(), 4'h0);
    do_xfer(1'b1, 32'h0000_2008, 32'h0BAD_F00D, 1, rnd128(), 4'b0100);
    do_xfer(1'b0, 32'h0000_0020, 32'h0, 0, rnd128(), 4'b0100);
    do_xfer(1'b0, 32'hFFFF_FFFF, 32'h0, 0, rnd128(), 4'h0);

`ifdef APB_DECODE_TIMEOUT_EN
    stall_then_reset(3);
    do_xfer(1'b0, 32'h0000_0000, 32'h0, 20, rnd128(), 4'h0);
    do_xfer(1'b0, 32'h0000_0004, 32'h0, TMO - 1, rnd128(), 4'h0);
    do_xfer(1'b1, 32'h0000_1000, 32'h7, TMO, rnd128(), 4'h0);
`else
    stall_then_reset(1000);
`endif
    do_xfer(1'b0, 32'h0000_1FFC, 32'h0, 1, rnd128(), 4'h0);

    for (int t = 0; t < 150; t++) begin
      wr = 1'($urandom);
      if ($urandom_range(3) == 0) addr = $urandom;
      else addr = (32'($urandom_range(NUM_SLV - 1)) << SEL_LSB) | 32'($urandom_range(4095));
`ifdef APB_DECODE_TIMEOUT_EN
      nw = $urandom_range(11);
`else
      nw = $urandom_range(3);
`endif
      do_xfer(wr, addr, $urandom, nw, rnd128(), 4'($urandom));
      if ($urandom_range(2) == 0) begin
        @(posedge clk); #1;
        s_psel = 1'b0; s_penable = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
